// File: rtl/axi2wbm_bridge_if.sv
// axi2wbm_bridge_if
//   Bundles the AXI4 (full) slave-side channels and the pipelined Wishbone
//   master-side signals of axi2wbm_bridge.
//   Modports:
//     slave  - the bridge's view: AXI responder, Wishbone initiator
//     master - the environment's view: AXI initiator, Wishbone peripheral
//   Signal groups: AW, W, B, AR, R channels (i_axi_* / o_axi_*) and
//   Wishbone cyc/stb/we/addr/data/sel out, stall/ack/err/data in.
interface axi2wbm_bridge_if #(
    parameter int C_AXI_ID_WIDTH   = 1,
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int C_AXI_ADDR_WIDTH = 28
);
    localparam int IDW  = C_AXI_ID_WIDTH;
    localparam int DW   = C_AXI_DATA_WIDTH;
    localparam int SELW = DW / 8;
    localparam int AW   = C_AXI_ADDR_WIDTH - $clog2(SELW);

    // Write address channel
    logic                        i_axi_awvalid;
    logic                        o_axi_awready;
    logic [IDW-1:0]              i_axi_awid;
    logic [C_AXI_ADDR_WIDTH-1:0] i_axi_awaddr;
    logic [7:0]                  i_axi_awlen;
    logic [2:0]                  i_axi_awsize;
    logic [1:0]                  i_axi_awburst;
    logic                        i_axi_awlock;
    logic [3:0]                  i_axi_awcache;
    logic [2:0]                  i_axi_awprot;
    logic [3:0]                  i_axi_awqos;
    // Write data channel
    logic                        i_axi_wvalid;
    logic                        o_axi_wready;
    logic [DW-1:0]               i_axi_wdata;
    logic [SELW-1:0]             i_axi_wstrb;
    logic                        i_axi_wlast;
    // Write response channel
    logic                        o_axi_bvalid;
    logic                        i_axi_bready;
    logic [IDW-1:0]              o_axi_bid;
    logic [1:0]                  o_axi_bresp;
    // Read address channel
    logic                        i_axi_arvalid;
    logic                        o_axi_arready;
    logic [IDW-1:0]              i_axi_arid;
    logic [C_AXI_ADDR_WIDTH-1:0] i_axi_araddr;
    logic [7:0]                  i_axi_arlen;
    logic [2:0]                  i_axi_arsize;
    logic [1:0]                  i_axi_arburst;
    logic                        i_axi_arlock;
    logic [3:0]                  i_axi_arcache;
    logic [2:0]                  i_axi_arprot;
    logic [3:0]                  i_axi_arqos;
    // Read data channel
    logic                        o_axi_rvalid;
    logic                        i_axi_rready;
    logic [IDW-1:0]              o_axi_rid;
    logic [DW-1:0]               o_axi_rdata;
    logic [1:0]                  o_axi_rresp;
    logic                        o_axi_rlast;
    // Wishbone pipelined master
    logic                        o_wb_cyc;
    logic                        o_wb_stb;
    logic                        o_wb_we;
    logic [AW-1:0]               o_wb_addr;
    logic [DW-1:0]               o_wb_data;
    logic [SELW-1:0]             o_wb_sel;
    logic                        i_wb_stall;
    logic                        i_wb_ack;
    logic                        i_wb_err;
    logic [DW-1:0]               i_wb_data;

    modport slave (
        input  i_axi_awvalid, i_axi_awid, i_axi_awaddr, i_axi_awlen, i_axi_awsize,
               i_axi_awburst, i_axi_awlock, i_axi_awcache, i_axi_awprot, i_axi_awqos,
        output o_axi_awready,
        input  i_axi_wvalid, i_axi_wdata, i_axi_wstrb, i_axi_wlast,
        output o_axi_wready,
        output o_axi_bvalid, o_axi_bid, o_axi_bresp,
        input  i_axi_bready,
        input  i_axi_arvalid, i_axi_arid, i_axi_araddr, i_axi_arlen, i_axi_arsize,
               i_axi_arburst, i_axi_arlock, i_axi_arcache, i_axi_arprot, i_axi_arqos,
        output o_axi_arready,
        output o_axi_rvalid, o_axi_rid, o_axi_rdata, o_axi_rresp, o_axi_rlast,
        input  i_axi_rready,
        output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel,
        input  i_wb_stall, i_wb_ack, i_wb_err, i_wb_data
    );

    modport master (
        output i_axi_awvalid, i_axi_awid, i_axi_awaddr, i_axi_awlen, i_axi_awsize,
               i_axi_awburst, i_axi_awlock, i_axi_awcache, i_axi_awprot, i_axi_awqos,
        input  o_axi_awready,
        output i_axi_wvalid, i_axi_wdata, i_axi_wstrb, i_axi_wlast,
        input  o_axi_wready,
        input  o_axi_bvalid, o_axi_bid, o_axi_bresp,
        output i_axi_bready,
        output i_axi_arvalid, i_axi_arid, i_axi_araddr, i_axi_arlen, i_axi_arsize,
               i_axi_arburst, i_axi_arlock, i_axi_arcache, i_axi_arprot, i_axi_arqos,
        input  o_axi_arready,
        input  o_axi_rvalid, o_axi_rid, o_axi_rdata, o_axi_rresp, o_axi_rlast,
        output i_axi_rready,
        input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel,
        output i_wb_stall, i_wb_ack, i_wb_err, i_wb_data
    );
endinterface

// File: rtl/axi2wbm_bridge.sv
// axi2wbm_bridge
//   AXI4 (full) slave to pipelined Wishbone master bridge. One burst in
//   flight at a time; each AXI beat becomes one single-word WB request, with
//   at most one WB request outstanding.
//   Ports:
//     i_clk   - bus clock
//     i_reset - synchronous active-high reset
//     bus     - axi2wbm_bridge_if.slave: AXI AW/W/B/AR/R channels and the
//               Wishbone cyc/stb/we/addr/data/sel, stall/ack/err/data signals
module axi2wbm_bridge #(
    parameter int C_AXI_ID_WIDTH   = 1,
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int C_AXI_ADDR_WIDTH = 28
) (
    input logic             i_clk,
    input logic             i_reset,
    axi2wbm_bridge_if.slave bus
);
    localparam int IDW  = C_AXI_ID_WIDTH;
    localparam int DW   = C_AXI_DATA_WIDTH;
    localparam int SELW = DW / 8;
    localparam int LSB  = $clog2(SELW);
    localparam int AW   = C_AXI_ADDR_WIDTH - LSB;

    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_BRESP, S_READ, S_RDATA} state_t;

    state_t          state;
    logic            awready_r, arready_r, bvalid_r, rvalid_r;
    logic            cyc_r, stb_r, we_r;
    logic            last_rd_r;   // last grant was a read: a tie goes to the write
    logic            err_r;       // a WB error occurred somewhere in this burst
    logic            rlast_r;
    logic [IDW-1:0]  id_r;
    logic [AW-1:0]   addr_r;
    logic [7:0]      len_r, beat_r;
    logic [1:0]      burst_r;
    logic [DW-1:0]   wdata_r, rdata_r;
    logic [SELW-1:0] sel_r;
    logic [1:0]      rresp_r;

    logic grant_w, grant_r, w_hs, last_beat;
    logic unused_inputs;

    // FIXED holds the address; INCR and WRAP both step by one word.
    function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a, input logic [1:0] burst);
        return (burst == 2'b00) ? a : a + AW'(1);
    endfunction

    assign grant_w   = bus.i_axi_awvalid && (!bus.i_axi_arvalid || last_rd_r);
    assign grant_r   = bus.i_axi_arvalid && !grant_w;
    assign last_beat = (beat_r == len_r);
    // W beats are taken only while no WB request is pending.
    assign w_hs      = bus.i_axi_wvalid && (state == S_WRITE) && !cyc_r;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state     <= S_IDLE;
            awready_r <= 1'b0;
            arready_r <= 1'b0;
            bvalid_r  <= 1'b0;
            rvalid_r  <= 1'b0;
            cyc_r     <= 1'b0;
            stb_r     <= 1'b0;
            last_rd_r <= 1'b1;
        end else begin
            awready_r <= 1'b0;
            arready_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (awready_r && bus.i_axi_awvalid) begin
                        id_r      <= bus.i_axi_awid;
                        addr_r    <= bus.i_axi_awaddr[C_AXI_ADDR_WIDTH-1:LSB];
                        len_r     <= bus.i_axi_awlen;
                        burst_r   <= bus.i_axi_awburst;
                        beat_r    <= 8'd0;
                        err_r     <= 1'b0;
                        last_rd_r <= 1'b0;
                        state     <= S_WRITE;
                    end else if (arready_r && bus.i_axi_arvalid) begin
                        id_r      <= bus.i_axi_arid;
                        addr_r    <= bus.i_axi_araddr[C_AXI_ADDR_WIDTH-1:LSB];
                        len_r     <= bus.i_axi_arlen;
                        burst_r   <= bus.i_axi_arburst;
                        beat_r    <= 8'd0;
                        err_r     <= 1'b0;
                        last_rd_r <= 1'b1;
                        cyc_r     <= 1'b1;
                        stb_r     <= 1'b1;
                        we_r      <= 1'b0;
                        sel_r     <= '1;
                        state     <= S_READ;
                    end else if (!awready_r && !arready_r) begin
                        // ready is a one-cycle pulse; the handshake lands next cycle
                        awready_r <= grant_w;
                        arready_r <= grant_r;
                    end
                end
                S_WRITE: begin
                    if (w_hs) begin
                        if (err_r) begin
                            // after an error, beats are drained without WB cycles
                            if (last_beat) begin
                                bvalid_r <= 1'b1;
                                state    <= S_BRESP;
                            end else begin
                                beat_r <= beat_r + 8'd1;
                            end
                        end else begin
                            cyc_r   <= 1'b1;
                            stb_r   <= 1'b1;
                            we_r    <= 1'b1;
                            wdata_r <= bus.i_axi_wdata;
                            sel_r   <= bus.i_axi_wstrb;
                        end
                    end
                    if (cyc_r) begin
                        if (!bus.i_wb_stall) stb_r <= 1'b0;
                        if (bus.i_wb_ack || bus.i_wb_err) begin
                            cyc_r <= 1'b0;
                            stb_r <= 1'b0;
                            if (bus.i_wb_err) err_r <= 1'b1;
                            if (last_beat) begin
                                bvalid_r <= 1'b1;
                                state    <= S_BRESP;
                            end else begin
                                beat_r <= beat_r + 8'd1;
                                addr_r <= next_addr(addr_r, burst_r);
                            end
                        end
                    end
                end
                S_BRESP: begin
                    if (bus.i_axi_bready) begin
                        bvalid_r <= 1'b0;
                        state    <= S_IDLE;
                    end
                end
                S_READ: begin
                    if (err_r) begin
                        rdata_r  <= '0;
                        rresp_r  <= 2'b10;
                        rlast_r  <= last_beat;
                        rvalid_r <= 1'b1;
                        state    <= S_RDATA;
                    end else if (cyc_r) begin
                        if (!bus.i_wb_stall) stb_r <= 1'b0;
                        if (bus.i_wb_ack || bus.i_wb_err) begin
                            cyc_r    <= 1'b0;
                            stb_r    <= 1'b0;
                            rlast_r  <= last_beat;
                            rvalid_r <= 1'b1;
                            state    <= S_RDATA;
                            if (bus.i_wb_err) begin
                                err_r   <= 1'b1;
                                rdata_r <= '0;
                                rresp_r <= 2'b10;
                            end else begin
                                rdata_r <= bus.i_wb_data;
                                rresp_r <= 2'b00;
                            end
                        end
                    end
                end
                S_RDATA: begin
                    if (bus.i_axi_rready) begin
                        rvalid_r <= 1'b0;
                        if (last_beat) begin
                            state <= S_IDLE;
                        end else begin
                            beat_r <= beat_r + 8'd1;
                            addr_r <= next_addr(addr_r, burst_r);
                            state  <= S_READ;
                            if (!err_r) begin
                                cyc_r <= 1'b1;
                                stb_r <= 1'b1;
                            end
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.o_axi_awready = awready_r;
    assign bus.o_axi_arready = arready_r;
    assign bus.o_axi_wready  = (state == S_WRITE) && !cyc_r;
    assign bus.o_axi_bvalid  = bvalid_r;
    assign bus.o_axi_bid     = id_r;
    assign bus.o_axi_bresp   = err_r ? 2'b10 : 2'b00;
    assign bus.o_axi_rvalid  = rvalid_r;
    assign bus.o_axi_rid     = id_r;
    assign bus.o_axi_rdata   = rdata_r;
    assign bus.o_axi_rresp   = rresp_r;
    assign bus.o_axi_rlast   = rlast_r;
    assign bus.o_wb_cyc      = cyc_r;
    assign bus.o_wb_stb      = stb_r;
    assign bus.o_wb_we       = we_r;
    assign bus.o_wb_addr     = addr_r;
    assign bus.o_wb_data     = wdata_r;
    assign bus.o_wb_sel      = sel_r;

    // Size, lock/cache/prot/qos, wlast and sub-word address bits carry no meaning here.
    assign unused_inputs = ^{bus.i_axi_awsize, bus.i_axi_awlock, bus.i_axi_awcache,
                             bus.i_axi_awprot, bus.i_axi_awqos, bus.i_axi_arsize,
                             bus.i_axi_arlock, bus.i_axi_arcache, bus.i_axi_arprot,
                             bus.i_axi_arqos, bus.i_axi_wlast,
                             bus.i_axi_awaddr[LSB-1:0], bus.i_axi_araddr[LSB-1:0]};
endmodule

// File: tb/tb_axi2wbm_bridge.sv
// tb_axi2wbm_bridge
//   Directed bench for axi2wbm_bridge: drives AXI bursts, models a pipelined
//   Wishbone peripheral (configurable stall, error injection, read data equal
//   to 0xC0DE0000 + word address) and compares against hand-computed values.
`timescale 1ns/1ps
module tb_axi2wbm_bridge;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    axi2wbm_bridge_if #(.C_AXI_ID_WIDTH(1), .C_AXI_DATA_WIDTH(32), .C_AXI_ADDR_WIDTH(28)) bus ();

    axi2wbm_bridge #(.C_AXI_ID_WIDTH(1), .C_AXI_DATA_WIDTH(32), .C_AXI_ADDR_WIDTH(28)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Wishbone peripheral model state
    int          stall_cfg    = 0;
    int          err_at       = -1;
    int          stall_cycles = 0;
    int          stb_drop     = 0;
    int          stall_cnt    = 0;
    bit          stalled_prev = 0;
    bit          resp_pend    = 0;
    bit          resp_err     = 0;
    logic [31:0] log_addr[$];
    bit          log_we[$];
    logic [31:0] log_data[$];
    logic [3:0]  log_sel[$];

    // Collected R beats
    logic [31:0] r_data[$];
    logic [1:0]  r_resp[$];
    bit          r_last[$];
    logic [0:0]  r_id[$];

    logic [0:0]  b_id;
    logic [1:0]  b_resp;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Pipelined WB peripheral, evaluated on the falling edge.
    initial begin
        bus.i_wb_stall = 1'b0;
        bus.i_wb_ack   = 1'b0;
        bus.i_wb_err   = 1'b0;
        bus.i_wb_data  = '0;
        forever begin
            @(negedge clk);
            bus.i_wb_ack = 1'b0;
            bus.i_wb_err = 1'b0;
            if (rst) begin
                resp_pend      = 0;
                stall_cnt      = 0;
                stalled_prev   = 0;
                bus.i_wb_stall = 1'b0;
            end else begin
                if (stalled_prev && !bus.o_wb_stb) stb_drop++;
                stalled_prev = 0;
                if (resp_pend) begin
                    if (resp_err) bus.i_wb_err = 1'b1;
                    else          bus.i_wb_ack = 1'b1;
                    resp_pend = 0;
                end else if (bus.o_wb_cyc && bus.o_wb_stb) begin
                    if (stall_cnt < stall_cfg) begin
                        bus.i_wb_stall = 1'b1;
                        stall_cnt++;
                        stall_cycles++;
                        stalled_prev = 1;
                    end else begin
                        bus.i_wb_stall = 1'b0;
                        stall_cnt      = 0;
                        resp_err       = (log_addr.size() == err_at);
                        bus.i_wb_data  = 32'hC0DE_0000 + 32'(bus.o_wb_addr);
                        log_addr.push_back(32'(bus.o_wb_addr));
                        log_we.push_back(bus.o_wb_we);
                        log_data.push_back(bus.o_wb_data);
                        log_sel.push_back(bus.o_wb_sel);
                        resp_pend = 1;
                    end
                end else begin
                    bus.i_wb_stall = 1'b0;
                end
            end
        end
    end

    task automatic clear_logs();
        log_addr.delete(); log_we.delete(); log_data.delete(); log_sel.delete();
    endtask

    task automatic set_aw(input logic [0:0] id, input logic [27:0] addr, input logic [7:0] len,
                          input logic [1:0] burst);
        bus.i_axi_awid = id; bus.i_axi_awaddr = addr; bus.i_axi_awlen = len;
        bus.i_axi_awburst = burst; bus.i_axi_awvalid = 1'b1;
    endtask

    task automatic set_ar(input logic [0:0] id, input logic [27:0] addr, input logic [7:0] len,
                          input logic [1:0] burst);
        bus.i_axi_arid = id; bus.i_axi_araddr = addr; bus.i_axi_arlen = len;
        bus.i_axi_arburst = burst; bus.i_axi_arvalid = 1'b1;
    endtask

    task automatic wait_aw(input string tag);
        int n = 0;
        while (!bus.o_axi_awready && n < 200) begin @(negedge clk); n++; end
        check_eq({tag, "_aw_hs"}, bus.o_axi_awready, 1);
        @(negedge clk);
        bus.i_axi_awvalid = 1'b0;
    endtask

    task automatic wait_ar(input string tag);
        int n = 0;
        while (!bus.o_axi_arready && n < 200) begin @(negedge clk); n++; end
        check_eq({tag, "_ar_hs"}, bus.o_axi_arready, 1);
        @(negedge clk);
        bus.i_axi_arvalid = 1'b0;
    endtask

    task automatic send_w(input string tag, input logic [31:0] d, input logic [3:0] s, input bit l);
        int n = 0;
        bus.i_axi_wdata = d; bus.i_axi_wstrb = s; bus.i_axi_wlast = l; bus.i_axi_wvalid = 1'b1;
        while (!bus.o_axi_wready && n < 200) begin @(negedge clk); n++; end
        check_eq({tag, "_w_hs"}, bus.o_axi_wready, 1);
        @(negedge clk);
        bus.i_axi_wvalid = 1'b0;
    endtask

    task automatic wait_b(input string tag);
        int n = 0;
        while (!bus.o_axi_bvalid && n < 200) begin @(negedge clk); n++; end
        check_eq({tag, "_bvalid"}, bus.o_axi_bvalid, 1);
        b_id   = bus.o_axi_bid;
        b_resp = bus.o_axi_bresp;
        @(negedge clk);
    endtask

    task automatic collect_r(input int nbeats);
        int t = 0;
        r_data.delete(); r_resp.delete(); r_last.delete(); r_id.delete();
        while (1) begin
            if (bus.o_axi_rvalid) begin
                r_data.push_back(bus.o_axi_rdata);
                r_resp.push_back(bus.o_axi_rresp);
                r_last.push_back(bus.o_axi_rlast);
                r_id.push_back(bus.o_axi_rid);
            end
            @(negedge clk);
            t++;
            if (r_data.size() >= nbeats || t >= 500) break;
        end
    endtask

    // Issue AW and AR on the same cycle and check who is granted first.
    task automatic tie_test(input string tag, input bit write_first, input logic [27:0] waddr,
                            input logic [27:0] raddr, input logic [31:0] exp_rdata);
        int n = 0;
        clear_logs();
        set_aw(1'b0, waddr, 8'd0, 2'b01);
        set_ar(1'b1, raddr, 8'd0, 2'b01);
        while (!bus.o_axi_awready && !bus.o_axi_arready && n < 200) begin @(negedge clk); n++; end
        check_eq({tag, "_write_first"}, bus.o_axi_awready, write_first);
        check_eq({tag, "_read_first"}, bus.o_axi_arready, !write_first);
        if (write_first) begin
            @(negedge clk);
            bus.i_axi_awvalid = 1'b0;
            send_w(tag, 32'h5555_AAAA, 4'hF, 1'b1);
            wait_b(tag);
            wait_ar(tag);
            collect_r(1);
        end else begin
            @(negedge clk);
            bus.i_axi_arvalid = 1'b0;
            collect_r(1);
            wait_aw(tag);
            send_w(tag, 32'h5555_AAAA, 4'hF, 1'b1);
            wait_b(tag);
        end
        check_eq({tag, "_rbeats"}, r_data.size(), 1);
        if (r_data.size() > 0) begin
            check_eq({tag, "_rdata"}, r_data[0], exp_rdata);
            check_eq({tag, "_rid"}, r_id[0], 1);
        end
        check_eq({tag, "_bresp"}, b_resp, 2'b00);
        check_eq({tag, "_wb_reqs"}, log_addr.size(), 2);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached after %0d checks", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        bus.i_axi_awvalid = 1'b0; bus.i_axi_awid = '0; bus.i_axi_awaddr = '0; bus.i_axi_awlen = '0;
        bus.i_axi_awsize = 3'b010; bus.i_axi_awburst = 2'b01; bus.i_axi_awlock = 1'b0;
        bus.i_axi_awcache = '0; bus.i_axi_awprot = '0; bus.i_axi_awqos = '0;
        bus.i_axi_wvalid = 1'b0; bus.i_axi_wdata = '0; bus.i_axi_wstrb = '0; bus.i_axi_wlast = 1'b0;
        bus.i_axi_bready = 1'b1;
        bus.i_axi_arvalid = 1'b0; bus.i_axi_arid = '0; bus.i_axi_araddr = '0; bus.i_axi_arlen = '0;
        bus.i_axi_arsize = 3'b010; bus.i_axi_arburst = 2'b01; bus.i_axi_arlock = 1'b0;
        bus.i_axi_arcache = '0; bus.i_axi_arprot = '0; bus.i_axi_arqos = '0;
        bus.i_axi_rready = 1'b1;

        repeat (3) @(negedge clk);
        check_eq("rst_awready", bus.o_axi_awready, 0);
        check_eq("rst_arready", bus.o_axi_arready, 0);
        check_eq("rst_wready",  bus.o_axi_wready, 0);
        check_eq("rst_bvalid",  bus.o_axi_bvalid, 0);
        check_eq("rst_rvalid",  bus.o_axi_rvalid, 0);
        check_eq("rst_cyc",     bus.o_wb_cyc, 0);
        check_eq("rst_stb",     bus.o_wb_stb, 0);
        rst = 1'b0;
        @(negedge clk);

        // Single write
        clear_logs();
        set_aw(1'b1, 28'h100, 8'd0, 2'b01);
        wait_aw("wr1");
        send_w("wr1", 32'hDEAD_BEEF, 4'hF, 1'b1);
        wait_b("wr1");
        check_eq("wr1_bid", b_id, 1);
        check_eq("wr1_bresp", b_resp, 2'b00);
        check_eq("wr1_reqs", log_addr.size(), 1);
        if (log_addr.size() == 1) begin
            check_eq("wr1_addr", log_addr[0], 32'h40);
            check_eq("wr1_we",   log_we[0], 1);
            check_eq("wr1_data", log_data[0], 32'hDEAD_BEEF);
            check_eq("wr1_sel",  log_sel[0], 4'hF);
        end

        // INCR read, 4 beats
        clear_logs();
        set_ar(1'b0, 28'h200, 8'd3, 2'b01);
        wait_ar("rd1");
        check_eq("rd1_stb_latency", bus.o_wb_stb, 1);
        check_eq("rd1_we", bus.o_wb_we, 0);
        collect_r(4);
        check_eq("rd1_beats", r_data.size(), 4);
        check_eq("rd1_reqs", log_addr.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < r_data.size()) begin
                check_eq($sformatf("rd1_rdata%0d", i), r_data[i], 32'hC0DE_0080 + 32'(i));
                check_eq($sformatf("rd1_rlast%0d", i), r_last[i], (i == 3));
                check_eq($sformatf("rd1_rresp%0d", i), r_resp[i], 2'b00);
                check_eq($sformatf("rd1_rid%0d", i), r_id[i], 0);
            end
            if (i < log_addr.size()) begin
                check_eq($sformatf("rd1_addr%0d", i), log_addr[i], 32'h80 + 32'(i));
                check_eq($sformatf("rd1_sel%0d", i), log_sel[i], 4'hF);
            end
        end

        // FIXED write, 3 beats, 3 stall cycles per beat
        clear_logs();
        stall_cfg = 3; stall_cycles = 0; stb_drop = 0;
        set_aw(1'b1, 28'h300, 8'd2, 2'b00);
        wait_aw("fx");
        send_w("fx", 32'h1111_1111, 4'h3, 1'b0);
        send_w("fx", 32'h2222_2222, 4'hF, 1'b0);
        send_w("fx", 32'h3333_3333, 4'hC, 1'b1);
        wait_b("fx");
        stall_cfg = 0;
        check_eq("fx_bresp", b_resp, 2'b00);
        check_eq("fx_bid", b_id, 1);
        check_eq("fx_reqs", log_addr.size(), 3);
        check_eq("fx_stall_cycles", stall_cycles, 9);
        check_eq("fx_stb_dropped_in_stall", stb_drop, 0);
        if (log_addr.size() == 3) begin
            check_eq("fx_addr0", log_addr[0], 32'hC0);
            check_eq("fx_addr1", log_addr[1], 32'hC0);
            check_eq("fx_addr2", log_addr[2], 32'hC0);
            check_eq("fx_data1", log_data[1], 32'h2222_2222);
            check_eq("fx_sel0",  log_sel[0], 4'h3);
            check_eq("fx_sel2",  log_sel[2], 4'hC);
        end

        // WB error on beat 1 of a 4-beat read
        clear_logs();
        err_at = 1;
        set_ar(1'b1, 28'h400, 8'd3, 2'b01);
        wait_ar("re");
        collect_r(4);
        err_at = -1;
        check_eq("re_beats", r_data.size(), 4);
        check_eq("re_reqs", log_addr.size(), 2);
        if (r_data.size() == 4) begin
            check_eq("re_rdata0", r_data[0], 32'hC0DE_0100);
            check_eq("re_rresp0", r_resp[0], 2'b00);
            check_eq("re_rdata1", r_data[1], 32'h0);
            check_eq("re_rresp1", r_resp[1], 2'b10);
            check_eq("re_rdata2", r_data[2], 32'h0);
            check_eq("re_rresp2", r_resp[2], 2'b10);
            check_eq("re_rdata3", r_data[3], 32'h0);
            check_eq("re_rresp3", r_resp[3], 2'b10);
            check_eq("re_rlast2", r_last[2], 0);
            check_eq("re_rlast3", r_last[3], 1);
        end

        // Arbitration: after a read, ties go to the write (twice); after a write, to the read
        tie_test("tie1", 1'b1, 28'h500, 28'h600, 32'hC0DE_0180);
        tie_test("tie2", 1'b1, 28'h504, 28'h604, 32'hC0DE_0181);
        clear_logs();
        set_aw(1'b0, 28'h700, 8'd0, 2'b01);
        wait_aw("wr2");
        send_w("wr2", 32'h0BAD_F00D, 4'hF, 1'b1);
        wait_b("wr2");
        check_eq("wr2_addr", (log_addr.size() == 1) ? log_addr[0] : 32'hFFFF_FFFF, 32'h1C0);
        tie_test("tie3", 1'b0, 28'h508, 28'h608, 32'hC0DE_0182);

        // Reset during beat 2 of a 4-beat write with stb stalled
        clear_logs();
        stall_cfg = 5;
        set_aw(1'b0, 28'h800, 8'd3, 2'b01);
        wait_aw("rs");
        send_w("rs", 32'hA0A0_A0A0, 4'hF, 1'b0);
        send_w("rs", 32'hA1A1_A1A1, 4'hF, 1'b0);
        send_w("rs", 32'hA2A2_A2A2, 4'hF, 1'b0);
        check_eq("rs_stb_pending", bus.o_wb_stb, 1);
        check_eq("rs_addr_beat2", 32'(bus.o_wb_addr), 32'h202);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rs_cyc_dropped", bus.o_wb_cyc, 0);
        check_eq("rs_stb_dropped", bus.o_wb_stb, 0);
        rst = 1'b0;
        stall_cfg = 0;
        begin
            int bseen = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (bus.o_axi_bvalid) bseen++;
            end
            check_eq("rs_no_bvalid", bseen, 0);
        end
        check_eq("rs_idle_wready", bus.o_axi_wready, 0);
        check_eq("rs_idle_cyc", bus.o_wb_cyc, 0);

        // After reset a tie goes to the write
        tie_test("tie_rst", 1'b1, 28'h900, 28'h904, 32'hC0DE_0241);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
